// File: rtl/board_serializer.sv
`default_nettype none
// ============================================================================
// Module      : board_serializer
// Description : Captures a W x H cellular-automaton board snapshot in one
//               cycle and streams it out one cell per valid/ready transfer,
//               in row-major order, with row/column tags and end-of-line /
//               end-of-frame markers. A one-cycle frame_done pulse follows
//               the last transfer.
//
// Parameters  : W  board width in cells  (2..256)
//               H  board height in cells (2..256)
//               L  flattened board length, bit index = row*W + col
//
// Ports       : clk          rising-edge clock
//               rst          asynchronous, active-high reset
//               start        capture request, honoured only while idle
//               board_in     [L-1:0] parallel snapshot, 1 = live cell
//               busy         high while streaming and in the done cycle
//               cell_valid   a cell is presented
//               cell_ready   sink accepts the presented cell
//               cell_data    state of the presented cell
//               cell_row     [7:0] row of the presented cell
//               cell_col     [7:0] column of the presented cell
//               cell_eol     presented cell is the last of its row
//               cell_last    presented cell is the last of the frame
//               frame_done   one-cycle pulse after the last transfer
//               population   [15:0] live cells in the last completed frame
//                            (present only with BOARD_SERIALIZER_POPCOUNT_EN)
//
// Option      : define BOARD_SERIALIZER_POPCOUNT_EN to build the live-cell
//               counter and the population port.
//
// Revision    : 1.0  initial release
// ============================================================================
module board_serializer #(
    parameter int W = 32,
    parameter int H = 24,
    parameter int L = W * H
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [L-1:0] board_in,
    output logic         busy,
    output logic         cell_valid,
    input  logic         cell_ready,
    output logic         cell_data,
    output logic [7:0]   cell_row,
    output logic [7:0]   cell_col,
    output logic         cell_eol,
    output logic         cell_last,
    output logic         frame_done
`ifdef BOARD_SERIALIZER_POPCOUNT_EN
    ,
    output logic [15:0]  population
`endif
);

    localparam logic [7:0] c_COL_LAST = 8'(W - 1);
    localparam logic [7:0] c_ROW_LAST = 8'(H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t       r_state;
    logic [L-1:0] r_shadow;
    logic [7:0]   r_row;
    logic [7:0]   r_col;
    logic         r_busy;
    logic         r_cell_valid;
    logic         r_cell_eol;
    logic         r_cell_last;
    logic         r_frame_done;

    logic         w_xfer;
    logic         w_col_wrap;
    logic [7:0]   w_col_next;
    logic [7:0]   w_row_next;
    logic         w_eol_next;
    logic         w_last_next;
    logic         w_capture;

    assign w_xfer    = r_cell_valid & cell_ready;
    assign w_capture = (r_state == ST_IDLE) & start;

    // Position of the cell that follows the one currently presented.
    assign w_col_wrap  = (r_col == c_COL_LAST);
    assign w_col_next  = w_col_wrap ? 8'd0 : (r_col + 8'd1);
    assign w_row_next  = w_col_wrap ? (r_row + 8'd1) : r_row;
    assign w_eol_next  = (w_col_next == c_COL_LAST);
    assign w_last_next = w_eol_next & (w_row_next == c_ROW_LAST);

    // The shadow copy is consumed LSB-first: every transfer shifts it right
    // by one, so bit 0 always holds shadow[row*W + col] of the original
    // snapshot. This replaces an L-to-1 multiplexer with a shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shadow     <= '0;
            r_row        <= 8'd0;
            r_col        <= 8'd0;
            r_busy       <= 1'b0;
            r_cell_valid <= 1'b0;
            r_cell_eol   <= 1'b0;
            r_cell_last  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (start) begin
                        r_shadow     <= board_in;
                        r_row        <= 8'd0;
                        r_col        <= 8'd0;
                        // W >= 2 and H >= 2, so cell (0,0) is never an
                        // end-of-line or end-of-frame cell.
                        r_cell_eol   <= 1'b0;
                        r_cell_last  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_cell_valid <= 1'b1;
                        r_state      <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (w_xfer) begin
                        r_shadow <= {1'b0, r_shadow[L-1:1]};
                        if (r_cell_last) begin
                            r_cell_valid <= 1'b0;
                            r_cell_eol   <= 1'b0;
                            r_cell_last  <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_row       <= w_row_next;
                            r_col       <= w_col_next;
                            r_cell_eol  <= w_eol_next;
                            r_cell_last <= w_last_next;
                        end
                    end
                end

                ST_DONE: begin
                    // Exactly one cycle; start is not looked at here, so a
                    // held start is taken in the following idle cycle.
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cell_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign cell_valid = r_cell_valid;
    assign cell_data  = r_shadow[0];
    assign cell_row   = r_row;
    assign cell_col   = r_col;
    assign cell_eol   = r_cell_eol;
    assign cell_last  = r_cell_last;
    assign frame_done = r_frame_done;

`ifdef BOARD_SERIALIZER_POPCOUNT_EN
    // Live-cell counter. The count wraps modulo 2^16, which only matters
    // for a fully live 256x256 board.
    logic [15:0] r_live_cnt;
    logic [15:0] r_population;
    logic [15:0] w_live_total;

    // Count including the cell being transferred this cycle.
    assign w_live_total = r_live_cnt + {15'd0, r_shadow[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live_cnt   <= 16'd0;
            r_population <= 16'd0;
        end else if (w_capture) begin
            r_live_cnt <= 16'd0;
        end else if (w_xfer) begin
            r_live_cnt <= w_live_total;
            // Loaded on the final transfer so it is valid in the same cycle
            // that frame_done is high.
            if (r_cell_last) begin
                r_population <= w_live_total;
            end
        end
    end

    assign population = r_population;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_serializer
// Description : Self-checking bench for board_serializer (W=4, H=3).
//               Expected streams are derived from the board value by index
//               arithmetic: cell i has data board[i], row i/W, col i%W.
// Revision    : 1.0  initial release
// ============================================================================
module tb_board_serializer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = W * H;

    logic         clk;
    logic         rst;
    logic         start;
    logic [L-1:0] board_in;
    logic         busy;
    logic         cell_valid;
    logic         cell_ready;
    logic         cell_data;
    logic [7:0]   cell_row;
    logic [7:0]   cell_col;
    logic         cell_eol;
    logic         cell_last;
    logic         frame_done;
`ifdef BOARD_SERIALIZER_POPCOUNT_EN
    logic [15:0]  population;
`endif

    board_serializer #(
        .W(W),
        .H(H),
        .L(L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board_in   (board_in),
        .busy       (busy),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_data  (cell_data),
        .cell_row   (cell_row),
        .cell_col   (cell_col),
        .cell_eol   (cell_eol),
        .cell_last  (cell_last),
        .frame_done (frame_done)
`ifdef BOARD_SERIALIZER_POPCOUNT_EN
        ,
        .population (population)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observations from the most recent run_frame call.
    logic [18:0] cap_cell [32];
    int          cap_n;
    int          done_pulses;
    int          stall_err;
    int          extra_valid;
    bit          timed_out;
    logic        valid_before;
    logic        valid_after;
    logic [15:0] cap_pop;

    function automatic logic ready_for(input int mode, input int cyc);
        int unsigned u;
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: begin
                u = $urandom_range(0, 1);
                return u[0];
            end
        endcase
    endfunction

    function automatic logic [18:0] model_cell(input logic [L-1:0] b, input int i);
        return {b[i], 8'(i / W), 8'(i % W), ((i % W) == (W - 1)), (i == (L - 1))};
    endfunction

    function automatic int model_pop(input logic [L-1:0] b);
        int n = 0;
        for (int i = 0; i < L; i++) n += int'(b[i]);
        return n;
    endfunction

    function automatic logic [L-1:0] rand_board();
        logic [31:0] r;
        r = $urandom;
        return r[L-1:0];
    endfunction

    // Drives one frame and records what the sink would see; no checks here.
    task automatic run_frame(input logic [L-1:0] board, input int mode,
                             input logic [L-1:0] board_after, input bit mid_start);
        bit          prev_stall;
        logic [18:0] prev;
        logic [18:0] cur;
        bit          done_seen;
        int          post;
        cap_n = 0; done_pulses = 0; stall_err = 0; extra_valid = 0;
        timed_out = 0; prev_stall = 0; done_seen = 0; post = 0; prev = '0;
        cap_pop = '0;
        @(posedge clk); #1;
        board_in   = board;
        start      = 1'b1;
        cell_ready = 1'b1;
        @(negedge clk);
        valid_before = cell_valid;
        @(posedge clk); #1;
        start    = 1'b0;
        board_in = board_after;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            cell_ready = ready_for(mode, cyc);
            start      = mid_start && (cyc == 3);
            @(negedge clk);
            cur = {cell_data, cell_row, cell_col, cell_eol, cell_last};
            if (cyc == 0) valid_after = cell_valid;
            if (done_seen && cell_valid) extra_valid++;
            if (cell_valid && prev_stall && (cur !== prev)) stall_err++;
            if (cell_valid && cell_ready) begin
                if (cap_n < 32) cap_cell[cap_n] = cur;
                cap_n++;
            end
            prev_stall = cell_valid && !cell_ready;
            prev       = cur;
            if (frame_done) begin
                done_pulses++;
                done_seen = 1;
`ifdef BOARD_SERIALIZER_POPCOUNT_EN
                cap_pop = population;
`endif
            end
            if (done_seen) begin
                post++;
                if (post > 4) break;
            end
        end
        if (!done_seen) timed_out = 1;
        cell_ready = 1'b0;
        start      = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        rst = 1'b1; start = 1'b0; cell_ready = 1'b0; board_in = '0;
        repeat (2) @(negedge clk);
        got = {busy, cell_valid, cell_data, cell_eol, cell_last, frame_done, cell_row, cell_col};
        checks++;
        if (got !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", got, 22'd0);
        end
`ifdef BOARD_SERIALIZER_POPCOUNT_EN
        checks++;
        if (population !== 16'd0) begin
            failures++;
            $display("FAIL reset_population: got %0d expected 0", population);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_stream(input logic [L-1:0] board, input int mode, input string name);
        logic [18:0] exp;
        run_frame(board, mode, board, 1'b0);
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL %s timeout: got no frame_done expected frame_done", name);
        end
        checks++;
        if (valid_before !== 1'b0 || valid_after !== 1'b1) begin
            failures++;
            $display("FAIL %s valid_latency: got before=%b after=%b expected 0/1",
                     name, valid_before, valid_after);
        end
        checks++;
        if (cap_n !== L) begin
            failures++;
            $display("FAIL %s transfer_count: got %0d expected %0d", name, cap_n, L);
        end
        checks++;
        if (done_pulses !== 1 || extra_valid !== 0) begin
            failures++;
            $display("FAIL %s frame_done: got pulses=%0d extra_valid=%0d expected 1/0",
                     name, done_pulses, extra_valid);
        end
        checks++;
        if (stall_err !== 0) begin
            failures++;
            $display("FAIL %s stall_hold: got %0d changes expected 0", name, stall_err);
        end
        for (int i = 0; i < L && i < cap_n; i++) begin
            exp = model_cell(board, i);
            checks++;
            if (cap_cell[i] !== exp) begin
                failures++;
                $display("FAIL %s cell%0d {data,row,col,eol,last}: got %h expected %h",
                         name, i, cap_cell[i], exp);
            end
        end
`ifdef BOARD_SERIALIZER_POPCOUNT_EN
        checks++;
        if (cap_pop !== 16'(model_pop(board))) begin
            failures++;
            $display("FAIL %s population: got %0d expected %0d", name, cap_pop, model_pop(board));
        end
`endif
    endtask

    task automatic test_capture_isolation();
        logic [L-1:0] b;
        logic [L-1:0] got;
        b = 12'hA51;
        run_frame(b, 0, 12'hFFF, 1'b1);
        got = '0;
        for (int i = 0; i < L && i < cap_n; i++) got[i] = cap_cell[i][18];
        checks++;
        if (got !== b || cap_n !== L) begin
            failures++;
            $display("FAIL isolation_data: got %h (n=%0d) expected %h (n=%0d)", got, cap_n, b, L);
        end
        checks++;
        if (done_pulses !== 1 || extra_valid !== 0 || timed_out) begin
            failures++;
            $display("FAIL isolation_no_requeue: got pulses=%0d extra_valid=%0d expected 1/0",
                     done_pulses, extra_valid);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [20:0] got;
        int          bad;
        @(posedge clk); #1;
        board_in = rand_board(); start = 1'b1; cell_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        got = {cell_valid, busy, frame_done, cell_eol, cell_last, cell_row, cell_col};
        checks++;
        if (got !== 21'd0) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", got, 21'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (cell_valid || frame_done || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_abandon: got %0d active cycles expected 0", bad);
        end
        cell_ready = 1'b0;
        test_stream(rand_board(), 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [L-1:0] b1;
        logic [L-1:0] b2;
        logic [L-1:0] got2;
        int           done_cnt;
        int           gap;
        int           n2;
        b1 = rand_board();
        b2 = ~b1;
        done_cnt = 0; gap = 0; n2 = 0; got2 = '0;
        @(posedge clk); #1;
        board_in = b1; start = 1'b1; cell_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (done_cnt == 1 && cell_valid && cell_ready) begin
                if (n2 < L) got2[n2] = cell_data;
                n2++;
            end
            if (done_cnt == 1 && !cell_valid && !frame_done && n2 == 0) gap++;
            if (frame_done) begin
                done_cnt++;
                board_in = b2;
                if (done_cnt == 2) break;
            end
        end
        start = 1'b0;
        cell_ready = 1'b0;
        checks++;
        if (done_cnt !== 2) begin
            failures++;
            $display("FAIL b2b_frames: got %0d expected 2", done_cnt);
        end
        checks++;
        if (gap !== 1) begin
            failures++;
            $display("FAIL b2b_idle_gap: got %0d expected 1", gap);
        end
        checks++;
        if (n2 !== L || got2 !== b2) begin
            failures++;
            $display("FAIL b2b_second_frame: got %h (n=%0d) expected %h (n=%0d)", got2, n2, b2, L);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cell_ready = 1'b0; board_in = '0;
        test_reset();
        test_stream(12'h000, 0, "zero_board");
        test_stream(12'hA51, 0, "a51_ready");
        test_stream(12'hA51, 1, "a51_stall");
        test_stream(12'h000, 0, "zero_after_a51");
        test_capture_isolation();
        test_mid_frame_reset();
        test_back_to_back();
        repeat (4) test_stream(rand_board(), 2, "random");
        test_stream(12'hFFF, 2, "full_board");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
